// File: rtl/uart_packet_receiver.sv
// Byte-stream parser: locates SYNC-framed packets, extracts the header and
// emits one UART_PACKET beat per payload byte, aborting stalled packets on timeout.
package uart_packet_pkg;
  typedef struct packed {
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
    logic [7:0] Data;
    logic       SoP;
    logic       EoP;
    logic       Valid;
  } UART_PACKET;
endpackage

// state  | meaning
// S_IDLE | hunting for SYNC; other bytes discarded
// S_DEST | next byte is Destination
// S_SRC  | next byte is Source
// S_LEN  | next byte is Length (0 returns to idle with no beat)
// S_DATA | payload bytes, one beat each
module uart_packet_receiver
  import uart_packet_pkg::*;
#(
  parameter logic [7:0]  SYNC    = 8'h55,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       ipClk,
  input  logic       ipReset,
  input  logic [7:0] ipRxData,
  input  logic       ipRxValid,
  output UART_PACKET opRxStream,
  output logic       opTimeout,
  output logic [7:0] opDropCount
);

  typedef enum logic [2:0] {S_IDLE, S_DEST, S_SRC, S_LEN, S_DATA} state_t;

  state_t     state_q;
  logic [7:0] dest_q;
  logic [7:0] src_q;
  logic [7:0] remain_q;
  logic [15:0] gap_q;
  UART_PACKET stream_q;
  logic       timeout_q;
  logic [7:0] drop_q;
  logic       abort_d;

  // A strobe on the would-be timeout cycle takes priority over the abort.
  assign abort_d = (state_q != S_IDLE) && !ipRxValid && (gap_q == TIMEOUT - 16'd1);

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state_q   <= S_IDLE;
      dest_q    <= '0;
      src_q     <= '0;
      remain_q  <= '0;
      gap_q     <= '0;
      stream_q  <= '0;
      timeout_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      stream_q.Valid <= 1'b0;
      stream_q.SoP   <= 1'b0;
      stream_q.EoP   <= 1'b0;
      timeout_q      <= 1'b0;
      if (ipRxValid) begin
        gap_q <= '0;
        case (state_q)
          S_IDLE: if (ipRxData == SYNC) state_q <= S_DEST;
          S_DEST: begin
            dest_q  <= ipRxData;
            state_q <= S_SRC;
          end
          S_SRC: begin
            src_q   <= ipRxData;
            state_q <= S_LEN;
          end
          S_LEN: begin
            stream_q.Destination <= dest_q;
            stream_q.Source      <= src_q;
            stream_q.Length      <= ipRxData;
            remain_q             <= ipRxData;
            state_q              <= (ipRxData == 8'd0) ? S_IDLE : S_DATA;
          end
          S_DATA: begin
            stream_q.Valid <= 1'b1;
            stream_q.Data  <= ipRxData;
            stream_q.SoP   <= (remain_q == stream_q.Length);
            stream_q.EoP   <= (remain_q == 8'd1);
            remain_q       <= remain_q - 8'd1;
            if (remain_q == 8'd1) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (abort_d) begin
        state_q   <= S_IDLE;
        gap_q     <= '0;
        timeout_q <= 1'b1;
        drop_q    <= drop_q + 8'd1;
      end else if (state_q != S_IDLE) begin
        gap_q <= gap_q + 16'd1;
      end
    end
  end

  assign opRxStream  = stream_q;
  assign opTimeout   = timeout_q;
  assign opDropCount = drop_q;

endmodule

// File: tb/tb_uart_packet_receiver.sv
// Directed plus randomized packet stimulus for uart_packet_receiver, checked
// against a packet-level expectation model kept in the bench.
module tb_uart_packet_receiver;
  import uart_packet_pkg::*;

  localparam int TO = 8;

  logic       ipClk = 1'b0;
  logic       ipReset;
  logic [7:0] ipRxData;
  logic       ipRxValid;
  UART_PACKET rx;
  logic       to;
  logic [7:0] dc;

  int checks = 0;
  int errors = 0;

  logic [7:0] last_data;
  logic [7:0] h_dest, h_src, h_len;
  logic [7:0] exp_drop;

  always #5 ipClk = ~ipClk;

  uart_packet_receiver #(.SYNC(8'h55), .TIMEOUT(16'(TO))) dut (
    .ipClk      (ipClk),
    .ipReset    (ipReset),
    .ipRxData   (ipRxData),
    .ipRxValid  (ipRxValid),
    .opRxStream (rx),
    .opTimeout  (to),
    .opDropCount(dc)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_hdr();
    chk("dest", 32'(rx.Destination), 32'(h_dest));
    chk("src", 32'(rx.Source), 32'(h_src));
    chk("len", 32'(rx.Length), 32'(h_len));
  endtask

  task automatic strobe(input logic [7:0] b);
    ipRxData  = b;
    ipRxValid = 1'b1;
    @(posedge ipClk); #1;
    ipRxValid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge ipClk); #1;
      chk("idle_valid", 32'(rx.Valid), 32'd0);
      chk("idle_timeout", 32'(to), 32'd0);
      chk("idle_data_hold", 32'(rx.Data), 32'(last_data));
    end
  endtask

  // Timeout pulse is visible TO steps after the last strobe.
  task automatic wait_abort();
    for (int k = 1; k <= TO + 1; k++) begin
      @(posedge ipClk); #1;
      if (k == TO) exp_drop = exp_drop + 8'd1;
      chk("abort_timeout", 32'(to), (k == TO) ? 32'd1 : 32'd0);
      chk("abort_dropcount", 32'(dc), 32'(exp_drop));
      chk("abort_valid", 32'(rx.Valid), 32'd0);
    end
  endtask

  task automatic send_pkt(input logic [7:0] d, input logic [7:0] s, input logic [7:0] l,
                          input logic [7:0] pl[$], input int nsend,
                          input int mingap, input int maxgap, input bit expect_abort);
    logic [7:0] b[$];
    b = {8'h55, d, s, l};
    foreach (pl[j]) b.push_back(pl[j]);
    for (int i = 0; i < nsend; i++) begin
      idle(int'($urandom_range(maxgap, mingap)));
      strobe(b[i]);
      chk("byte_timeout", 32'(to), 32'd0);
      if (i == 3) begin
        h_dest = d; h_src = s; h_len = l;
        check_hdr();
        chk("hdr_valid", 32'(rx.Valid), 32'd0);
      end else if (i >= 4) begin
        last_data = b[i];
        chk("beat_valid", 32'(rx.Valid), 32'd1);
        chk("beat_data", 32'(rx.Data), 32'(b[i]));
        chk("beat_sop", 32'(rx.SoP), (i == 4) ? 32'd1 : 32'd0);
        chk("beat_eop", 32'(rx.EoP), (i == 3 + int'(l)) ? 32'd1 : 32'd0);
        check_hdr();
      end else begin
        chk("pre_valid", 32'(rx.Valid), 32'd0);
        chk("pre_data_hold", 32'(rx.Data), 32'(last_data));
      end
    end
    if (expect_abort && nsend < b.size()) wait_abort();
  endtask

  task automatic check_reset_state();
    chk("rst_src", 32'(rx.Source), 32'd0);
    chk("rst_dest", 32'(rx.Destination), 32'd0);
    chk("rst_len", 32'(rx.Length), 32'd0);
    chk("rst_data", 32'(rx.Data), 32'd0);
    chk("rst_sop", 32'(rx.SoP), 32'd0);
    chk("rst_eop", 32'(rx.EoP), 32'd0);
    chk("rst_valid", 32'(rx.Valid), 32'd0);
    chk("rst_timeout", 32'(to), 32'd0);
    chk("rst_dropcount", 32'(dc), 32'd0);
  endtask

  initial begin
    logic [7:0] pl[$];
    int l, total, nsend;
    logic [7:0] g;

    ipReset = 1'b1; ipRxValid = 1'b0; ipRxData = 8'h00;
    last_data = 8'h00; h_dest = 8'h00; h_src = 8'h00; h_len = 8'h00; exp_drop = 8'h00;
    repeat (2) @(posedge ipClk);
    #1 ipReset = 1'b0;
    check_reset_state();

    strobe(8'hAA);
    chk("stray_valid", 32'(rx.Valid), 32'd0);
    check_hdr();
    idle(2);

    // basic read request, 3-cycle gaps
    pl = {8'h11, 8'h22};
    send_pkt(8'h00, 8'h01, 8'h02, pl, 6, 3, 3, 1'b0);
    idle(3);

    // length 0 then length 1, back to back
    pl = {};
    send_pkt(8'h05, 8'h06, 8'h00, pl, 4, 0, 0, 1'b0);
    pl = {8'h7E};
    send_pkt(8'h05, 8'h06, 8'h01, pl, 5, 0, 0, 1'b0);
    idle(2);

    // in-band SYNC inside payload
    pl = {8'h55, 8'h55};
    send_pkt(8'h00, 8'h00, 8'h02, pl, 6, 0, 2, 1'b0);

    // truncated packet aborts, then a full packet parses
    pl = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_pkt(8'h00, 8'h01, 8'h04, pl, 5, 0, 2, 1'b1);
    pl = {8'h31, 8'h32, 8'h33};
    send_pkt(8'h09, 8'h08, 8'h03, pl, 7, 0, 2, 1'b0);

    // every byte lands on the would-be timeout cycle
    pl = {8'h41, 8'h42};
    send_pkt(8'h12, 8'h34, 8'h02, pl, 6, TO - 1, TO - 1, 1'b0);
    chk("simul_dropcount", 32'(dc), 32'(exp_drop));

    // randomized traffic with garbage bytes and occasional truncation
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(3, 0) == 0) begin
        g = 8'($urandom_range(255, 0));
        if (g == 8'h55) g = 8'h54;
        strobe(g);
        chk("garbage_valid", 32'(rx.Valid), 32'd0);
      end
      l = int'($urandom_range(5, 0));
      pl = {};
      for (int j = 0; j < l; j++) pl.push_back(8'($urandom_range(255, 0)));
      total = 4 + l;
      nsend = ($urandom_range(3, 0) == 0) ? int'($urandom_range(total - 1, 1)) : total;
      send_pkt(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 8'(l), pl,
               nsend, 0, TO - 1, 1'b1);
    end
    idle(2);
    chk("rand_dropcount", 32'(dc), 32'(exp_drop));

    // reset mid-DATA: nothing more emitted, drop not counted
    pl = {8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(8'h07, 8'h06, 8'h04, pl, 6, 0, 1, 1'b0);
    ipReset = 1'b1; ipRxData = 8'h03; ipRxValid = 1'b1;
    @(posedge ipClk); #1;
    ipReset = 1'b0; ipRxValid = 1'b0;
    exp_drop = 8'h00; last_data = 8'h00; h_dest = 8'h00; h_src = 8'h00; h_len = 8'h00;
    check_reset_state();
    for (int k = 0; k < TO + 3; k++) begin
      @(posedge ipClk); #1;
      chk("postrst_valid", 32'(rx.Valid), 32'd0);
      chk("postrst_eop", 32'(rx.EoP), 32'd0);
      chk("postrst_timeout", 32'(to), 32'd0);
    end
    chk("postrst_dropcount", 32'(dc), 32'd0);
    pl = {8'hE1, 8'hE2};
    send_pkt(8'h0A, 8'h0B, 8'h02, pl, 6, 0, 2, 1'b0);

    // 256 aborts wrap the drop counter back to zero
    pl = {};
    for (int n = 0; n < 256; n++) send_pkt(8'h00, 8'h00, 8'h00, pl, 1, 0, 0, 1'b1);
    chk("wrap_dropcount", 32'(dc), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_packet_receiver.md
# uart_packet_receiver

Parses the raw byte stream from the UART receiver into framed `UART_PACKET` beats, one beat per payload byte. It sits directly upstream of the read controller and the other register controllers, and drives their `opRxStream` input. It locates packet boundaries and extracts the header fields. A stalled, truncated packet is aborted by an inter-byte timeout, so the receiver recovers without a reset.

## Interface
Parameters:
- `SYNC`, 8'h55: start-of-packet marker byte.
- `TIMEOUT`, 16'd50000: maximum idle clock cycles allowed between bytes of one packet. Must be ≥ 2.

Ports:
- `ipClk`  in  1  system clock; single clock domain.
- `ipReset`  in  1  synchronous, active-high reset.
- `ipRxData`  in  8  byte from the UART receiver.
- `ipRxValid`  in  1  one-cycle strobe; `ipRxData` is valid on this cycle.
- `opRxStream`  out  `UART_PACKET`  fields: `Source[7:0]`, `Destination[7:0]`, `Length[7:0]`, `Data[7:0]`, `SoP`, `EoP`, `Valid`.
- `opTimeout`  out  1  one-cycle pulse when a packet is aborted.
- `opDropCount`  out  8  number of aborted packets; wraps at 255→0.

## Operation
- Wire format: `SYNC`, Destination, Source, Length, then Length payload bytes.
- States: IDLE, DEST, SRC, LEN, DATA. Each state advances only on a cycle with `ipRxValid`=1.
  - IDLE: a byte equal to `SYNC` moves to DEST. Any other byte is discarded.
  - DEST: latch Destination; go to SRC.
  - SRC: latch Source; go to LEN.
  - LEN: latch Length and load the payload counter with Length. If Length=0, return to IDLE and emit no beat. Otherwise go to DATA.
- DATA: every byte produces exactly one output beat.
  - Beat contents: `Data`=byte and `Valid`=1.
  - `SoP`=1 on the first payload byte; `EoP`=1 on the last.
  - Length=1 asserts `SoP` and `EoP` on the same beat.
  - After the last byte, go to IDLE.
- A `SYNC` value arriving in DEST, SRC, LEN or DATA is ordinary field or payload data. It does not resynchronise.
- Header field stability: `Destination`, `Source` and `Length` on `opRxStream` update when LEN completes. They then hold until the next packet's LEN completes, so they are stable across all beats of a packet.
- `Data` holds its last value when `Valid`=0.
- Timeout:
  - A gap counter clears on every `ipRxValid`. It increments on every other cycle while the state is not IDLE.
  - If the counter reaches `TIMEOUT`-1 on a cycle with no `ipRxValid`, the FSM returns to IDLE. On that abort, `opTimeout` pulses for one cycle and `opDropCount` increments.
  - An aborted packet emits no further beats and no `EoP`. Downstream discards a packet whose `SoP` is not followed by `EoP` before the next `SoP`.
- Simultaneous events: an `ipRxValid` on the cycle the timeout would fire wins. The byte is accepted, the counter clears and no abort occurs.
- Reset:
  - Synchronous; takes priority over all other inputs, including mid-packet.
  - State goes to IDLE; the gap counter is cleared.
  - All `opRxStream` fields are 0; `opTimeout`=0; `opDropCount`=0.
  - Any partially received packet is lost and is not counted as a drop.

## Timing
- All outputs are registered.
- A payload byte strobed on cycle n appears on `opRxStream` with `Valid`=1 on cycle n+1, for exactly one cycle.
- There is no backpressure: `ipRxValid` strobes can arrive on consecutive cycles, and a beat is emitted on each following cycle.
- Header latency: Destination, Source and Length become visible one cycle after the LEN byte is strobed.
- `opTimeout` is asserted on the cycle after the abort condition; `opDropCount` updates on that same cycle.
- Minimum packet-to-packet spacing is zero cycles. A `SYNC` strobed on the cycle immediately after the last payload byte starts a new packet.

## Test plan
- Reset values:
  - Stimulus: hold `ipReset`=1 for 2 cycles, then release.
  - Response: all outputs are 0, and a stray byte 8'hAA is ignored.
- Basic read request:
  - Stimulus: bytes 55,00,01,02,11,22 with 3-cycle gaps.
  - Response: Destination=00, Source=01, Length=02.
  - Two beats: Data=11 with `SoP` only, then Data=22 with `EoP` only, each one cycle after its strobe.
- Length edge cases:
  - Stimulus: packet 55,05,06,00, then 55,05,06,01,7E on back-to-back cycles.
  - Response: no beat for the first packet.
  - One beat with Data=7E, `SoP`=`EoP`=1, for the second.
- In-band sync: payload 55,55 (packet 55,00,00,02,55,55).
  - Response: two beats with Data=55 each; no resynchronisation.
- Timeout abort:
  - Stimulus: `TIMEOUT`=8; send 55,00,01,04,AA, then idle.
  - Response: one beat with `SoP`, and no `EoP`.
  - `opTimeout` pulses after 8 idle cycles and `opDropCount`=1.
  - A following full packet parses correctly.
- Simultaneous and wrap events:
  - Stimulus: a byte strobed exactly on the timeout cycle.
  - Response: no abort.
  - Stimulus: 256 forced aborts.
  - Response: `opDropCount` wraps to 0.
  - Stimulus: `ipReset` mid-DATA.
  - Response: IDLE with no `EoP` emitted.
